// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = {NUM_REQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux_4_to_1_vector.sv
// SIZE-bit 4:1 vector multiplexer; only the zero-delay (purely combinational) form is built.
module mux_4_to_1_vector #(
  parameter int SIZE  = 4,
  parameter int DELAY = 0
) (
  input  logic [1:0]      sel,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [SIZE-1:0] c,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] y
);

  if (DELAY != 0) begin : g_delay_unsupported
    $error("mux_4_to_1_vector: only DELAY=0 is implemented");
  end

  // plain select
  always_comb begin
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      2'd3:    y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request after 'last', with 'last' itself lowest.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  // scan last+1 .. last+4 (mod 4) and keep the first hit
  always_comb begin
    logic [IDX_W-1:0] cand;
    any_o    = 1'b0;
    winner_o = {IDX_W{1'b0}};
    cand     = {IDX_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_i + IDX_W'(k);
      if (!any_o && req_i[cand]) begin
        any_o    = 1'b1;
        winner_o = cand;
      end else begin
        any_o    = any_o;
        winner_o = winner_o;
      end
    end
  end

endmodule

// File: rtl/mux_4_to_1_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux, with bounded bursts
// and a valid/ready handshake toward a single consumer.
module mux_4_to_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [SIZE-1:0]    a,
  input  logic [SIZE-1:0]    b,
  input  logic [SIZE-1:0]    c,
  input  logic [SIZE-1:0]    d,
  input  logic               y_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   sel,
  output logic [SIZE-1:0]    y,
  output logic               y_valid,
  output logic               beat
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_any_s;
  logic [IDX_W-1:0]   pick_win_s;
  logic [IDX_W-1:0]   pick_last_s;
  logic               valid_s;
  logic               beat_s;
  logic               release_s;

  // On release the current owner becomes 'last', so a same-edge re-pick scans from sel.
  assign pick_last_s = (state_q == GRANT) ? sel_q : last_q;

  rr_pick4 u_pick (
    .req_i    (req),
    .last_i   (pick_last_s),
    .any_o    (pick_any_s),
    .winner_o (pick_win_s)
  );

  assign valid_s   = (state_q == GRANT) && req[sel_q];
  assign beat_s    = valid_s && y_ready;
  assign release_s = (state_q == GRANT) &&
                     (!req[sel_q] || (beat_s && (cnt_q == LAST_BEAT)));

  // next-state for grant ownership, burst counting and rotation
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = GRANT;
          grant_d = onehot(pick_win_s);
          sel_d   = pick_win_s;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          last_d = sel_q;
          if (pick_any_s) begin
            state_d = GRANT;
            grant_d = onehot(pick_win_s);
            sel_d   = pick_win_s;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = IDLE;
            grant_d = {NUM_REQ{1'b0}};
          end
        end else if (beat_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= {NUM_REQ{1'b0}};
      sel_q   <= {IDX_W{1'b0}};
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  mux_4_to_1_vector #(
    .SIZE  (SIZE),
    .DELAY (0)
  ) u_mux (
    .sel (sel_q),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .y   (y)
  );

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign y_valid = valid_s;
  assign beat    = beat_s;

endmodule
